// File: rtl/counter_seq_pkg.sv
// Shared definitions for the counter sequencer: register map, CTRL/STATUS bits, FSM states.
package counter_seq_pkg;

  localparam int unsigned WB_DW = 32;
  localparam int unsigned IDX_W = 3;

  localparam logic [IDX_W-1:0] IDX_CTRL     = 3'd0;
  localparam logic [IDX_W-1:0] IDX_PRESCALE = 3'd1;
  localparam logic [IDX_W-1:0] IDX_LOAD     = 3'd2;
  localparam logic [IDX_W-1:0] IDX_COMPARE  = 3'd3;
  localparam logic [IDX_W-1:0] IDX_STATUS   = 3'd4;
  localparam logic [IDX_W-1:0] IDX_COUNT    = 3'd5;
  localparam logic [IDX_W-1:0] IDX_SNAPSHOT = 3'd6;

  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_STOP    = 1;
  localparam int unsigned CTRL_ONESHOT = 2;
  localparam int unsigned CTRL_IRQ_EN  = 3;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_MATCH     = 1;
  localparam int unsigned STAT_STATE_LSB = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Byte-lane merge of a WB write into an existing register value.
  function automatic logic [WB_DW-1:0] byte_merge(input logic [WB_DW-1:0] old_v,
                                                   input logic [WB_DW-1:0] new_v,
                                                   input logic [3:0]       sel);
    logic [WB_DW-1:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Wishbone slave bus bundle for the counter sequencer.
interface counter_seq_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/counter_seq_prescaler.sv
// Prescaler for the counter sequencer: ticks every limit+1 run cycles; limit is re-sampled on clear and wrap.
module counter_seq_prescaler #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         run_i,
  input  logic [W-1:0] limit_i,
  output logic         tick_c
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] lim_q, lim_d;

  always_comb begin
    cnt_d  = cnt_q;
    lim_d  = lim_q;
    tick_c = run_i && (cnt_q == lim_q);
    if (clear_i || tick_c) begin
      cnt_d = '0;
      lim_d = limit_i;
    end else if (run_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      lim_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Wishbone-controlled sequencer for the user-area counter: load/compare/prescale registers, strobes, match IRQ.
// Optional COUNTER_SEQ_SNAPSHOT_EN adds a read-only SNAPSHOT register at 0x18.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int unsigned BITS       = 32,
  parameter int unsigned PRESCALE_W = 16,
  parameter logic [31:0] ADDR_BASE  = 32'h3000_0000
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  counter_seq_ctrl_if.slave    wbs,
  input  logic [BITS-1:0]      cnt_value_i,
  output logic                 cnt_load_o,
  output logic [BITS-1:0]      cnt_load_val_o,
  output logic                 cnt_en_o,
  output logic                 busy_o,
  output logic                 irq_o
);

  state_e                  state_q, state_d;
  logic                    ack_q, ack_d;
  logic [WB_DW-1:0]        rdat_q, rdat_d;
  logic                    oneshot_q, oneshot_d;
  logic                    irq_en_q, irq_en_d;
  logic [PRESCALE_W-1:0]   prescale_q, prescale_d;
  logic [BITS-1:0]         load_q, load_d;
  logic [BITS-1:0]         compare_q, compare_d;
  logic                    match_q, match_d;
  logic                    check_q, check_d;
  logic                    cnt_load_q, cnt_load_d;
  logic                    busy_q, busy_d;
  logic                    irq_q, irq_d;
`ifdef COUNTER_SEQ_SNAPSHOT_EN
  logic [BITS-1:0]         snap_q, snap_d;
`endif

  logic                    acc_c, in_base_c, wr_c, byte0_wr_c;
  logic                    start_c, stop_c, w1c_c, hit_c, tick_c, cnt_en_c;
  logic [IDX_W-1:0]        idx_c;
  logic [WB_DW-1:0]        rdata_c;
  logic                    unused_c;

  // Bus decode: one access per valid phase, ack suppresses an immediate repeat.
  assign acc_c      = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q;
  assign in_base_c  = (wbs.wbs_adr_i[31:8] == ADDR_BASE[31:8]);
  assign idx_c      = wbs.wbs_adr_i[4:2];
  assign wr_c       = acc_c & wbs.wbs_we_i & in_base_c;
  assign byte0_wr_c = wr_c & wbs.wbs_sel_i[0];
  assign start_c    = byte0_wr_c && (idx_c == IDX_CTRL) && wbs.wbs_dat_i[CTRL_START];
  assign stop_c     = byte0_wr_c && (idx_c == IDX_CTRL) && wbs.wbs_dat_i[CTRL_STOP];
  assign w1c_c      = byte0_wr_c && (idx_c == IDX_STATUS) && wbs.wbs_dat_i[STAT_MATCH];
  assign hit_c      = check_q && (cnt_value_i == compare_q);
  assign unused_c   = ^{wbs.wbs_adr_i[7:5], wbs.wbs_adr_i[1:0], ADDR_BASE[7:0]};

  counter_seq_prescaler #(.W(PRESCALE_W)) u_prescaler (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .clear_i (state_q == ST_LOAD),
    .run_i   (state_q == ST_RUN),
    .limit_i (prescale_q),
    .tick_c  (tick_c)
  );

  always_comb begin
    rdata_c = '0;
    if (in_base_c) begin
      case (idx_c)
        IDX_CTRL: begin
          rdata_c[CTRL_ONESHOT] = oneshot_q;
          rdata_c[CTRL_IRQ_EN]  = irq_en_q;
        end
        IDX_PRESCALE: rdata_c = WB_DW'(prescale_q);
        IDX_LOAD:     rdata_c = WB_DW'(load_q);
        IDX_COMPARE:  rdata_c = WB_DW'(compare_q);
        IDX_STATUS: begin
          rdata_c[STAT_BUSY]             = busy_q;
          rdata_c[STAT_MATCH]            = match_q;
          rdata_c[STAT_STATE_LSB +: 2]   = state_q;
        end
        IDX_COUNT:    rdata_c = WB_DW'(cnt_value_i);
`ifdef COUNTER_SEQ_SNAPSHOT_EN
        IDX_SNAPSHOT: rdata_c = WB_DW'(snap_q);
`endif
        default:      rdata_c = '0;
      endcase
    end
  end

  always_comb begin
    ack_d      = acc_c;
    rdat_d     = (acc_c && !wbs.wbs_we_i) ? rdata_c : '0;
    oneshot_d  = oneshot_q;
    irq_en_d   = irq_en_q;
    prescale_d = prescale_q;
    load_d     = load_q;
    compare_d  = compare_q;
    state_d    = state_q;
`ifdef COUNTER_SEQ_SNAPSHOT_EN
    snap_d     = hit_c ? cnt_value_i : snap_q;
`endif

    if (byte0_wr_c && (idx_c == IDX_CTRL)) begin
      oneshot_d = wbs.wbs_dat_i[CTRL_ONESHOT];
      irq_en_d  = wbs.wbs_dat_i[CTRL_IRQ_EN];
    end
    if (wr_c) begin
      case (idx_c)
        IDX_PRESCALE: prescale_d = PRESCALE_W'(byte_merge(WB_DW'(prescale_q), wbs.wbs_dat_i, wbs.wbs_sel_i));
        IDX_LOAD:     load_d     = BITS'(byte_merge(WB_DW'(load_q), wbs.wbs_dat_i, wbs.wbs_sel_i));
        IDX_COMPARE:  compare_d  = BITS'(byte_merge(WB_DW'(compare_q), wbs.wbs_dat_i, wbs.wbs_sel_i));
        default: ;
      endcase
    end

    // A match detected in the same cycle as a W1C clear must survive.
    match_d = hit_c ? 1'b1 : (w1c_c ? 1'b0 : match_q);

    case (state_q)
      ST_IDLE, ST_DONE: if (start_c && !stop_c) state_d = ST_LOAD;
      ST_LOAD:          state_d = ST_RUN;
      ST_RUN: begin
        if (stop_c)                   state_d = ST_IDLE;
        else if (start_c)             state_d = ST_LOAD;
        else if (oneshot_q && hit_c)  state_d = ST_DONE;
      end
      default:          state_d = ST_IDLE;
    endcase

    // Increment only while staying in RUN so a oneshot match stops the count in the match cycle.
    cnt_en_c   = tick_c && (state_q == ST_RUN) && (state_d == ST_RUN);
    check_d    = cnt_load_q | cnt_en_c;
    cnt_load_d = (state_d == ST_LOAD);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_RUN);
    irq_d      = match_d & irq_en_d;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q    <= ST_IDLE;
      ack_q      <= 1'b0;
      rdat_q     <= '0;
      oneshot_q  <= 1'b0;
      irq_en_q   <= 1'b0;
      prescale_q <= '0;
      load_q     <= '0;
      compare_q  <= '0;
      match_q    <= 1'b0;
      check_q    <= 1'b0;
      cnt_load_q <= 1'b0;
      busy_q     <= 1'b0;
      irq_q      <= 1'b0;
`ifdef COUNTER_SEQ_SNAPSHOT_EN
      snap_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      rdat_q     <= rdat_d;
      oneshot_q  <= oneshot_d;
      irq_en_q   <= irq_en_d;
      prescale_q <= prescale_d;
      load_q     <= load_d;
      compare_q  <= compare_d;
      match_q    <= match_d;
      check_q    <= check_d;
      cnt_load_q <= cnt_load_d;
      busy_q     <= busy_d;
      irq_q      <= irq_d;
`ifdef COUNTER_SEQ_SNAPSHOT_EN
      snap_q     <= snap_d;
`endif
    end
  end

  assign wbs.wbs_ack_o  = ack_q;
  assign wbs.wbs_dat_o  = rdat_q;
  assign cnt_load_o     = cnt_load_q;
  assign cnt_load_val_o = load_q;
  assign cnt_en_o       = cnt_en_c;
  assign busy_o         = busy_q;
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: bus/register/IRQ/strobe-spacing model checked every cycle plus directed scenarios.
module tb_counter_seq_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00, A_PRE = BASE + 32'h04, A_LOAD = BASE + 32'h08;
  localparam logic [31:0] A_CMP = BASE + 32'h0C, A_STAT = BASE + 32'h10, A_COUNT = BASE + 32'h14;
  localparam logic [31:0] A_SNAP = BASE + 32'h18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cnt_val;
  logic        cnt_load, cnt_en, busy, irq;
  logic [31:0] load_val;

  int total = 0;
  int bad = 0;
  int n_load = 0;
  int n_en = 0;
  int cyc_n = 0;
  bit chk_en = 1'b0;

  counter_seq_ctrl_if bus();

  counter_seq_ctrl #(.BITS(32), .PRESCALE_W(16), .ADDR_BASE(BASE)) dut (
    .wb_clk_i       (clk),
    .wb_rst_ni      (rst_n),
    .wbs            (bus),
    .cnt_value_i    (cnt_val),
    .cnt_load_o     (cnt_load),
    .cnt_load_val_o (load_val),
    .cnt_en_o       (cnt_en),
    .busy_o         (busy),
    .irq_o          (irq)
  );

  always #5 clk = ~clk;

  // Counter core stand-in.
  always @(posedge clk) begin
    if (!rst_n)        cnt_val <= '0;
    else if (cnt_load) cnt_val <= load_val;
    else if (cnt_en)   cnt_val <= cnt_val + 32'd1;
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  // Reference model state (values the DUT outputs must show after each edge).
  logic [15:0] m_prescale;
  logic [31:0] m_load, m_compare, m_rd_exp;
  logic        m_oneshot, m_irq_en, m_match, m_ack_exp, m_irq_exp, m_rd_chk, strb_prev, sp_valid;
  int          sp_last;

  always @(posedge clk) begin
    logic acc, inb, hit, w1c;
    logic [2:0] idx;
    cyc_n++;
    if (!rst_n) begin
      m_prescale = '0; m_load = '0; m_compare = '0; m_oneshot = 0; m_irq_en = 0; m_match = 0;
      m_ack_exp = 0; m_irq_exp = 0; m_rd_chk = 0; strb_prev = 0; sp_valid = 0; sp_last = 0;
      m_rd_exp = '0;
    end else begin
      acc = bus.wbs_cyc_i && bus.wbs_stb_i && !bus.wbs_ack_o;
      inb = (bus.wbs_adr_i[31:8] == BASE[31:8]);
      idx = bus.wbs_adr_i[4:2];
      hit = strb_prev && (cnt_val == m_compare);
      w1c = acc && bus.wbs_we_i && inb && idx == 3'd4 && bus.wbs_sel_i[0] && bus.wbs_dat_i[1];
      m_match = hit ? 1'b1 : (w1c ? 1'b0 : m_match);
      m_rd_chk = 0;
      if (acc && !bus.wbs_we_i) begin
        m_rd_chk = 1;
        if (!inb || idx == 3'd7) m_rd_exp = '0;
        else if (idx == 3'd0)    m_rd_exp = {28'd0, m_irq_en, m_oneshot, 2'b00};
        else if (idx == 3'd1)    m_rd_exp = {16'd0, m_prescale};
        else if (idx == 3'd2)    m_rd_exp = m_load;
        else if (idx == 3'd3)    m_rd_exp = m_compare;
        else                     m_rd_chk = 0;
      end
      if (acc && bus.wbs_we_i && inb) begin
        case (idx)
          3'd0: if (bus.wbs_sel_i[0]) begin
                  m_oneshot = bus.wbs_dat_i[2];
                  m_irq_en  = bus.wbs_dat_i[3];
                end
          3'd1: m_prescale = 16'(merge({16'd0, m_prescale}, bus.wbs_dat_i, bus.wbs_sel_i));
          3'd2: m_load     = merge(m_load, bus.wbs_dat_i, bus.wbs_sel_i);
          3'd3: m_compare  = merge(m_compare, bus.wbs_dat_i, bus.wbs_sel_i);
          default: ;
        endcase
      end
      m_irq_exp = m_match & m_irq_en;
      m_ack_exp = acc;
      // Every increment strobe lands exactly PRESCALE+1 cycles after the previous load/increment.
      if (cnt_load) begin
        sp_last = cyc_n; sp_valid = 1;
      end else if (cnt_en) begin
        if (sp_valid) check("en_spacing", 32'(cyc_n - sp_last), 32'(m_prescale) + 32'd1);
        sp_last = cyc_n;
      end
      strb_prev = cnt_load | cnt_en;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ack", {31'd0, bus.wbs_ack_o}, {31'd0, m_ack_exp});
      check("load_val", load_val, m_load);
      check("irq", {31'd0, irq}, {31'd0, m_irq_exp});
      if (m_rd_chk && bus.wbs_ack_o) check("rdata", bus.wbs_dat_o, m_rd_exp);
      if (cnt_en) check("en_needs_busy", {31'd0, busy}, 32'd1);
      if (cnt_load || cnt_en) check("strobe_excl", {31'd0, cnt_load & cnt_en}, 32'd0);
      if (cnt_load) n_load++;
      if (cnt_en)   n_en++;
    end
  end

  task automatic wb(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel, output logic [31:0] rd);
    bit got = 0;
    rd = '0;
    @(negedge clk);
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr; bus.wbs_dat_i = dat; bus.wbs_sel_i = sel;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) begin got = 1; rd = bus.wbs_dat_o; end
    end
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    if (!got) begin
      total++; bad++;
      $display("FAIL wb_timeout: no ack for adr 0x%08h", adr);
    end
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] d;
    wb(1'b1, adr, dat, 4'hF, d);
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] d);
    wb(1'b0, adr, 32'd0, 4'hF, d);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  pat;
    int e0, l0;
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    bus.wbs_sel_i = '0; bus.wbs_dat_i = '0; bus.wbs_adr_i = '0;

    // Reset
    repeat (4) @(posedge clk);
    chk_en = 1;
    @(negedge clk);
    check("rst_outputs", {26'd0, bus.wbs_ack_o, cnt_load, cnt_en, busy, irq, |load_val}, 32'd0);
    check("rst_dat", bus.wbs_dat_o, 32'd0);
    rst_n = 1;
    rd(A_STAT, d); check("rst_status", d, 32'h0);

    // Oneshot 5 -> 8
    wr(A_LOAD, 32'd5); wr(A_CMP, 32'd8); wr(A_PRE, 32'd0);
    n_load = 0; n_en = 0;
    wr(A_CTRL, 32'h05);
    repeat (20) @(negedge clk);
    check("oneshot_loads", 32'(n_load), 32'd1);
    check("oneshot_ens", 32'(n_en), 32'd3);
    check("oneshot_irq", {31'd0, irq}, 32'd0);
    rd(A_STAT, d);  check("oneshot_status", d, 32'h0E);
    rd(A_COUNT, d); check("oneshot_count", d, 32'd8);

    // Free-run, prescale 3, IRQ enabled
    wr(A_STAT, 32'h02);
    rd(A_STAT, d); check("w1c_status", d, 32'h0C);
    wr(A_LOAD, 32'd0); wr(A_CMP, 32'd3); wr(A_PRE, 32'd3);
    wr(A_CTRL, 32'h09);
    rd(A_CTRL, d); check("ctrl_selfclear", d, 32'h08);
    for (int i = 0; i < 60 && !irq; i++) @(negedge clk);
    check("freerun_irq_set", {31'd0, irq}, 32'd1);
    wr(A_STAT, 32'h02);
    check("freerun_irq_clr", {31'd0, irq}, 32'd0);
    e0 = n_en;
    repeat (12) @(negedge clk);
    check("freerun_continues", 32'(n_en - e0), 32'd3);
    check("freerun_busy", {31'd0, busy}, 32'd1);

    // START|STOP together: stop wins
    wr(A_CTRL, 32'h03);
    e0 = n_en; l0 = n_load;
    repeat (20) @(negedge clk);
    check("stop_no_en", 32'(n_en - e0), 32'd0);
    check("stop_no_load", 32'(n_load - l0), 32'd0);
    check("stop_busy", {31'd0, busy}, 32'd0);
    rd(A_COUNT, d); check("stop_count_hold", d, cnt_val);
    rd(A_STAT, d);  check("stop_status", d, 32'h00);

    // Held strobe: ack every other cycle
    @(negedge clk);
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_adr_i = A_CTRL; bus.wbs_sel_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pat[3-i] = bus.wbs_ack_o;
    end
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
    check("ack_pattern", {28'd0, pat}, 32'hA);

    // Byte-select, unmapped and out-of-base accesses
    wr(A_LOAD, 32'h1122_3344);
    wb(1'b1, A_LOAD, 32'hAABB_CCDD, 4'b0010, d);
    rd(A_LOAD, d); check("sel_load", d, 32'h1122_CC44);
    check("sel_load_port", load_val, 32'h1122_CC44);
    rd(BASE + 32'h1C, d); check("unmapped_1c", d, 32'd0);
    wr(32'h3000_0108, 32'hDEAD_BEEF);
    rd(A_LOAD, d); check("oob_write_dropped", d, 32'h1122_CC44);
    rd(32'h3000_0100, d); check("oob_read", d, 32'd0);

    // Snapshot on match at 0x10
    wr(A_LOAD, 32'h0C); wr(A_CMP, 32'h10); wr(A_PRE, 32'd0);
    wr(A_CTRL, 32'h05);
    repeat (20) @(negedge clk);
    rd(A_STAT, d); check("snap_status", d, 32'h0E);
    rd(A_SNAP, d);
`ifdef COUNTER_SEQ_SNAPSHOT_EN
    check("snapshot", d, 32'h10);
`else
    check("snapshot_absent", d, 32'h0);
`endif

    // Reset in the middle of RUN
    wr(A_STAT, 32'h02);
    wr(A_CMP, 32'hFFFF_0000);
    wr(A_CTRL, 32'h01);
    repeat (6) @(negedge clk);
    check("mid_run_busy", {31'd0, busy}, 32'd1);
    rst_n = 0;
    @(posedge clk); #1;
    check("rst_mid_strobes", {29'd0, cnt_en, cnt_load, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    rd(A_STAT, d); check("rst_mid_status", d, 32'h0);
    rd(A_LOAD, d); check("rst_mid_load", d, 32'h0);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
